// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-result text transmitter: FSM state
// encodings and the ASCII constants used to format hex output.
package mat_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_SEND = 3'd2,
        S_INCR = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] ALPHA = 8'h41;

    // Index width for a counter covering 0..n-1, never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex2ascii.sv
// Combinational nibble to uppercase hex ASCII character.
module hex2ascii
    import mat_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'.
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ZERO + {4'd0, nibble};
        end else begin
            ascii = ALPHA + {4'd0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/mat_result_tx.sv
// Streams a captured frame of matrix results to a UART as hex text:
// N_HEX digits per element, space-separated, CR after every N_COL elements.
module mat_result_tx
    import mat_pkg::*;
#(
    parameter int N_ELEM = 16,
    parameter int N_COL  = 4,
    parameter int ELEM_W = 18,
    parameter int N_HEX  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N_ELEM*ELEM_W-1:0] results,
    input  logic                     is_transmitting,
    output logic                     transmit,
    output logic [7:0]               tx_byte,
    output logic                     busy,
    output logic                     done
);

    localparam int EW      = idx_w(N_ELEM);
    localparam int DW      = idx_w(N_HEX + 1);
    localparam int CW      = idx_w(N_COL);
    localparam int N_BYTES = N_ELEM * (N_HEX + 1);
    localparam int BW      = idx_w(N_BYTES);
    localparam int PAD_W   = N_HEX * 4;

    state_t                     state;
    logic [N_ELEM*ELEM_W-1:0]   captured;
    logic [EW-1:0]              elem_idx;
    logic [DW-1:0]              digit_idx;
    logic [CW-1:0]              col_idx;
    logic [BW-1:0]              byte_cnt;

    logic [EW-1:0]              nxt_elem;
    logic [DW-1:0]              nxt_digit;
    logic [CW-1:0]              nxt_col;

    logic [N_ELEM*ELEM_W-1:0]   sel_src;
    logic [EW-1:0]              sel_elem;
    logic [DW-1:0]              sel_digit;
    logic [CW-1:0]              sel_col;
    logic [ELEM_W-1:0]          sel_word;
    logic [PAD_W-1:0]           sel_pad;
    logic [3:0]                 sel_nibble;
    logic [7:0]                 digit_ascii;
    logic [7:0]                 sel_byte;

    // Position of the byte after the current one: digits 0..N_HEX-1 then the
    // separator slot N_HEX, after which the element and column counters step.
    always_comb begin
        nxt_elem  = elem_idx;
        nxt_digit = digit_idx + DW'(1);
        nxt_col   = col_idx;
        if (digit_idx == DW'(N_HEX)) begin
            nxt_digit = '0;
            nxt_elem  = elem_idx + EW'(1);
            nxt_col   = (col_idx == CW'(N_COL - 1)) ? '0 : col_idx + CW'(1);
        end
    end

    // Choose which position/data the next registered tx_byte is built from:
    // the live input at frame start, the advanced position when stepping.
    always_comb begin
        sel_src   = captured;
        sel_elem  = elem_idx;
        sel_digit = digit_idx;
        sel_col   = col_idx;
        if (state == S_IDLE) begin
            sel_src   = results;
            sel_elem  = '0;
            sel_digit = '0;
            sel_col   = '0;
        end else if (state == S_INCR) begin
            sel_elem  = nxt_elem;
            sel_digit = nxt_digit;
            sel_col   = nxt_col;
        end
    end

    // Extract the selected element, zero-extend it and pick its nibble, MSB first.
    always_comb begin
        sel_word   = sel_src[int'(sel_elem)*ELEM_W +: ELEM_W];
        sel_pad    = PAD_W'(sel_word);
        sel_nibble = '0;
        for (int i = 0; i < N_HEX; i++) begin
            if (sel_digit == DW'(N_HEX - 1 - i)) begin
                sel_nibble = sel_pad[i*4 +: 4];
            end
        end
    end

    hex2ascii u_hex2ascii (
        .nibble (sel_nibble),
        .ascii  (digit_ascii)
    );

    // Separator slot emits space or CR depending on the column; otherwise a digit.
    always_comb begin
        if (sel_digit == DW'(N_HEX)) begin
            sel_byte = (sel_col == CW'(N_COL - 1)) ? CR : SPACE;
        end else begin
            sel_byte = digit_ascii;
        end
    end

    // Frame sequencer with registered UART handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            captured  <= '0;
            elem_idx  <= '0;
            digit_idx <= '0;
            col_idx   <= '0;
            byte_cnt  <= '0;
            tx_byte   <= 8'h00;
            transmit  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        captured  <= results;
                        elem_idx  <= '0;
                        digit_idx <= '0;
                        col_idx   <= '0;
                        byte_cnt  <= '0;
                        tx_byte   <= sel_byte;
                        transmit  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (is_transmitting) begin
                        transmit <= 1'b0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!is_transmitting) begin
                        state <= S_INCR;
                    end
                end
                S_INCR: begin
                    if (byte_cnt == BW'(N_BYTES - 1)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        byte_cnt  <= byte_cnt + BW'(1);
                        elem_idx  <= nxt_elem;
                        digit_idx <= nxt_digit;
                        col_idx   <= nxt_col;
                        tx_byte   <= sel_byte;
                        transmit  <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    transmit <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
